// File: rtl/mux_nto1_stream.sv
// N-to-1 stream multiplexer with valid/ready on every channel and one registered output stage.
// Selection is either a fixed external index or fair round-robin from the last served channel.
module mux_nto1_stream #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  input  logic                      out_ready
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_chan_q;
  logic [SELW-1:0]  last_q;

  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant;
  logic [WIDTH-1:0] grant_data;
  int unsigned      idx;

  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    if (!mode) begin
      // Out-of-range sel simply matches no channel.
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          grant_vld = 1'b1;
          grant     = SELW'(i);
        end
      end
    end else begin
      // Scan farthest offset first so the nearest requester after last_q wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        idx = (int'(last_q) + k) % CHANNELS;
        for (int i = 0; i < CHANNELS; i++) begin
          if (idx == i && in_valid[i]) begin
            grant_vld = 1'b1;
            grant     = SELW'(i);
          end
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && load_en && grant_vld) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (grant == SELW'(i)) in_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      last_q      <= SELW'(CHANNELS - 1);
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data;
        out_chan_q  <= grant;
        last_q      <= grant;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Bench for mux_nto1_stream: a 4-channel and a 3-channel instance share stimulus and are
// checked every cycle against a queue-free behavioural model plus directed literal checks.
module tb_mux_nto1_stream;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  in_ready4;
  logic        out_valid4;
  logic [7:0]  out_data4;
  logic [1:0]  out_chan4;

  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;

  int total = 0;
  int bad   = 0;

  mux_nto1_stream #(.WIDTH(8), .CHANNELS(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_chan(out_chan4), .out_ready(out_ready)
  );

  mux_nto1_stream #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid[2:0]), .in_data(in_data[23:0]), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_chan(out_chan3), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: winner under the selection rules, -1 when nobody is granted.
  function automatic int pick(int n, logic m, int s, logic [3:0] v, int l);
    if (!m) return (s < n && v[s]) ? s : -1;
    for (int k = 1; k <= n; k++) begin
      if (v[(l + k) % n]) return (l + k) % n;
    end
    return -1;
  endfunction

  bit   m_init = 0;
  logic m_valid [2];
  int   m_data  [2];
  int   m_chan  [2];
  int   m_last  [2];

  // Compare, then advance the model to the state after the coming rising edge.
  always @(negedge clk) begin
    if (!m_init && rst) begin
      m_init = 1;
      for (int d = 0; d < 2; d++) m_valid[d] = 1'b0;
    end
    if (m_init) begin
      for (int d = 0; d < 2; d++) begin
        int n;
        int g;
        logic [3:0] v;
        logic le;
        logic [31:0] exp_rdy;
        n  = (d == 0) ? 4 : 3;
        v  = (d == 0) ? in_valid : {1'b0, in_valid[2:0]};
        g  = pick(n, mode, int'(sel), v, m_last[d]);
        le = !m_valid[d] || out_ready;
        exp_rdy = (!rst && le && g >= 0) ? (32'd1 << g) : 32'd0;
        if (d == 0) begin
          chk("rdy4", {28'd0, in_ready4}, exp_rdy);
          chk("vld4", {31'd0, out_valid4}, {31'd0, m_valid[0]});
          if (m_valid[0]) begin
            chk("dat4", {24'd0, out_data4}, m_data[0]);
            chk("chn4", {30'd0, out_chan4}, m_chan[0]);
          end
        end else begin
          chk("rdy3", {29'd0, in_ready3}, exp_rdy);
          chk("vld3", {31'd0, out_valid3}, {31'd0, m_valid[1]});
          if (m_valid[1]) begin
            chk("dat3", {24'd0, out_data3}, m_data[1]);
            chk("chn3", {30'd0, out_chan3}, m_chan[1]);
          end
        end
        if (rst) begin
          m_valid[d] = 1'b0;
          m_data[d]  = 0;
          m_chan[d]  = 0;
          m_last[d]  = n - 1;
        end else if (le) begin
          if (g >= 0) begin
            m_valid[d] = 1'b1;
            m_data[d]  = int'(in_data[g*8 +: 8]);
            m_chan[d]  = g;
            m_last[d]  = g;
          end else begin
            m_valid[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int seq_rr  [6] = '{3, 0, 1, 2, 3, 0};
  int seq_alt [4] = '{1, 3, 1, 3};

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'h0; in_data = 32'h0; out_ready = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_vld", {31'd0, out_valid4}, 32'd0);
    chk("rst_dat", {24'd0, out_data4}, 32'd0);
    chk("rst_chn", {30'd0, out_chan4}, 32'd0);

    // Fixed select of channel 2.
    sel = 2'd2; in_valid = 4'hF; in_data = 32'h44_A5_22_11;
    #1 chk("fix_rdy", {28'd0, in_ready4}, 32'h4);
    step(1);
    chk("fix_vld", {31'd0, out_valid4}, 32'd1);
    chk("fix_dat", {24'd0, out_data4}, 32'hA5);
    chk("fix_chn", {30'd0, out_chan4}, 32'd2);
    chk("fix_rdy2", {28'd0, in_ready4}, 32'h4);

    // Round-robin continues after the last served channel (2).
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("rr_vld", {31'd0, out_valid4}, 32'd1);
      chk("rr_chn", {30'd0, out_chan4}, seq_rr[i]);
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("alt_chn", {30'd0, out_chan4}, seq_alt[i]);
    end
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("one_chn", {30'd0, out_chan4}, 32'd1);
    end

    // Backpressure holds 0x3C for three cycles.
    mode = 1'b0; sel = 2'd1; in_data = 32'h00_00_3C_00;
    step(1);
    out_ready = 1'b0; in_data = 32'h00_00_5A_00;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("bp_dat", {24'd0, out_data4}, 32'h3C);
      chk("bp_chn", {30'd0, out_chan4}, 32'd1);
      chk("bp_rdy", {28'd0, in_ready4}, 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel", {28'd0, in_ready4}, 32'h2);
    step(1);
    chk("bp_vld", {31'd0, out_valid4}, 32'd1);
    chk("bp_new", {24'd0, out_data4}, 32'h5A);

    // Selected channel idle; then sel=3 on the 3-channel instance.
    sel = 2'd2; in_valid = 4'b1011;
    #1 chk("idle_rdy", {28'd0, in_ready4}, 32'd0);
    step(1);
    chk("idle_vld", {31'd0, out_valid4}, 32'd0);
    sel = 2'd3; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("c3_rdy", {29'd0, in_ready3}, 32'd0);
      chk("c3_vld", {31'd0, out_valid3}, 32'd0);
    end

    // Reset while holding a beat with the pointer at 2.
    mode = 1'b1; in_valid = 4'b0100;
    step(1);
    chk("pre_chn", {30'd0, out_chan4}, 32'd2);
    rst = 1'b1; in_valid = 4'hF;
    #1 chk("rst_rdy", {28'd0, in_ready4}, 32'd0);
    step(1);
    rst = 1'b0;
    chk("post_vld", {31'd0, out_valid4}, 32'd0);
    step(1);
    chk("post_chn", {30'd0, out_chan4}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_nto1_stream.md
Name: mux_nto1_stream

Overview:
- Parametrised N-to-1, W-bit multiplexer with valid/ready handshakes on every input channel and on the output, and one registered output stage.
- Two selection modes: fixed, where the external sel picks the channel, and round-robin, where the block arbitrates fairly among requesting channels.
- Used wherever several producer streams share one consumer. It replaces ad-hoc gate-level 2:1 muxes on datapaths that need flow control.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- CHANNELS, 4, number of input channels (>=2).
- SELW, $clog2(CHANNELS), width of sel and out_chan. This is a derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index in fixed mode; ignored in round-robin mode.
- in_valid  input  CHANNELS  bit i: channel i has data.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  bit i: channel i transfer accepted this cycle.
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered data.
- out_chan  output  SELW  source channel index of out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last=CHANNELS-1, so channel 0 has first priority.
  - in_ready is all-zero while rst=1.
- Load enable: load_en = !out_valid || out_ready. The output register accepts a new beat whenever it is empty or being drained in the same cycle.
- Grant (combinational from current mode/sel/in_valid/last):
  - Fixed mode: grant = sel, only if sel < CHANNELS and in_valid[sel]=1. Otherwise no grant. sel >= CHANNELS means no grant.
  - Round-robin mode: grant = first i with in_valid[i]=1, scanning last+1, last+2, ... with wrap modulo CHANNELS. No requester means no grant.
- Handshakes:
  - in_ready[i] = load_en && grant valid && grant==i. At most one bit is set (one-hot or zero).
  - in_ready must not depend on in_valid of the same channel in a way that forms a loop with the producer. Producers must not gate in_valid on in_ready.
  - An input transfer occurs when in_valid[i] && in_ready[i].
- On an input transfer at the clk edge:
  - out_data <= in_data[grant], out_chan <= grant, out_valid <= 1.
  - last <= grant. This applies in both modes, so switching to round-robin continues fairly from the last served channel.
- If load_en=1 and there is no grant: out_valid <= 0. out_data and out_chan hold their values (don't-care when out_valid=0; the bench checks them only when valid).
- If load_en=0 (out_valid=1, out_ready=0): all output registers hold. in_ready=0. No input is consumed.
- Latency and throughput: 1 cycle from input transfer to out_valid. Sustained throughput is 1 beat/cycle when out_ready stays high.
- Output stability: while out_valid=1 && out_ready=0, out_data and out_chan are stable.
- Mode/sel changes: take effect on the next grant computation (same cycle, combinational). They never corrupt a beat already held in the output register.
- Reset mid-operation: an in-flight beat in the output register is discarded, and the pointer returns to CHANNELS-1. in_ready=0 during reset, so no input is consumed on the reset edge.
- CHANNELS not a power of two: round-robin wrap is modulo CHANNELS, never 2^SELW. Indices >= CHANNELS are never granted.

Test Plan:
- Reset then fixed mode, WIDTH=8, CHANNELS=4, sel=2, in_valid=4'b1111, in_data ch2=0xA5, out_ready=1 -> in_ready=4'b0100 every cycle; out_valid=1, out_data=0xA5, out_chan=2 one cycle after the first accept.
- Round-robin, all four valid, out_ready=1 continuously -> grants/out_chan sequence 0,1,2,3,0,1... with one beat per cycle and no bubbles.
- Round-robin, in_valid=4'b1010 -> out_chan alternates 1,3,1,3. Then drop ch3 -> only 1 repeats; ch0 and ch2 are never granted.
- Backpressure: a beat 0x3C is held with out_ready=0 for 3 cycles -> out_data=0x3C and out_chan stay stable, in_ready=0. On out_ready=1, the next beat loads in the same cycle (out_valid stays 1).
- Fixed mode with sel=2 and in_valid[2]=0, others valid -> in_ready=0 and out_valid falls to 0 after the drain. With CHANNELS=3 and sel=3 -> never any grant.
- Assert rst for 1 cycle while out_valid=1 and the pointer=2 -> next cycle out_valid=0 and in_ready=0 during reset. First round-robin grant afterward is channel 0.
